uio_bus_arbiter: RTL

UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

---
 rtl/uio_bus_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/uio_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared 8-bit uio pad bus.
// Inserts turnaround cycles on direction change and parks the bus after each transfer.
module uio_bus_arbiter #(
  parameter int XFER_CYC = 2,
  parameter int TURN_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic [7:0] rdata,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN, XFER} state_t;

  localparam logic [3:0] XFER_LAST = 4'(XFER_CYC - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

  state_t     state, next;
  logic [3:0] cnt;
  logic       cur_b, cur_we;
  logic [7:0] cur_wdata;
  logic       last_dir;   // 1 = last completed transfer was a write
  logic       last_b;     // 1 = B was granted most recently
  logic       pick_a, pick_b;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next   = state;
    pick_a = 1'b0;
    pick_b = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_a && (!req_b || last_b)) pick_a = 1'b1;
        else if (req_b)                  pick_b = 1'b1;
        if (pick_a || pick_b) next = GRANT;
      end
      GRANT: next = (cur_we != last_dir) ? TURN : XFER;
      TURN:  if (cnt == TURN_LAST) next = XFER;
      XFER:  if (cnt == XFER_LAST) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      cur_b     <= 1'b0;
      cur_we    <= 1'b0;
      cur_wdata <= '0;
      last_dir  <= 1'b0;
      last_b    <= 1'b1;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      rdata     <= '0;
      uio_out   <= '0;
      uio_oe    <= '0;
      busy      <= 1'b0;
    end else begin
      cnt    <= (next != state) ? 4'd0 : cnt + 4'd1;
      gnt_a  <= pick_a;
      gnt_b  <= pick_b;
      done_a <= 1'b0;
      done_b <= 1'b0;
      busy   <= (next != IDLE);
      if (pick_a || pick_b) begin
        cur_b     <= pick_b;
        cur_we    <= pick_a ? we_a : we_b;
        cur_wdata <= pick_a ? wdata_a : wdata_b;
        last_b    <= pick_b;
      end
      // Outside TURN/XFER the pads keep whatever the last transfer left (parking).
      if (next == TURN) uio_oe <= 8'h00;
      if (next == XFER) begin
        uio_oe <= cur_we ? 8'hFF : 8'h00;
        if (cur_we) uio_out <= cur_wdata;
      end
      if (state == XFER && next == IDLE) begin
        done_a   <= !cur_b;
        done_b   <= cur_b;
        last_dir <= cur_we;
        if (!cur_we) rdata <= uio_in;
      end
    end
  end

endmodule
